uart_rx_mmio: RTL
=================

Name: uart_rx_mmio

Overview:
- Memory-mapped UART receiver on the PicoRV32 native bus.
- Decoded at 0x2000_0000 alongside the existing transmitter; turns the otherwise unused i_rx pin into a CPU-readable byte stream.
- Serial deframer (8N1, programmable divider) feeds a byte FIFO that the CPU drains through a three-register window.
- Upstream of the CPU's read path; the top-level mem mux consumes its mem_ready/mem_rdata.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, reset baud rate. DIV reset value = CLK_HZ/BAUD, integer division.
- FIFO_DEPTH, 16, receive FIFO entries. Power of two, 2..256.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  bus request, already qualified by the top-level address decode.
- mem_addr  in  32  byte address; only [3:2] decoded.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; zero means read.
- mem_ready  out  1  one-cycle acknowledge.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- rx  in  1  asynchronous serial input, idle high.
- irq_rx  out  1  level high while the FIFO is non-empty.

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, irq_rx=0, FIFO empty, sticky flags 0, DIV=CLK_HZ/BAUD, deframer IDLE.
- Bus handshake:
  - Request accepted when mem_valid && !mem_ready.
  - mem_ready is registered and pulses exactly one cycle after acceptance.
  - A request still asserted in the ready cycle is not re-accepted, so there is no double pop.
- Register map (mem_addr[3:2]):
  - 0 DATA. Read returns {24'b0, byte} and pops. If the FIFO is empty, read returns 32'hFFFF_FFFF with no pop. Writes are ignored.
  - 1 STATUS, read-only except W1C on bits 2-4. Bit0 rx_avail, bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky), bit4 parity_err (sticky). Bits 31:5 read 0.
  - 2 DIV, R/W bits [15:0]; upper bits read 0. A written value below 4 is stored as 4. The new value takes effect at the next start bit, never mid-frame.
  - 3 reads 0, writes ignored.
  - Any write completes with mem_ready one cycle later.
- Input synchronisation: 2-flop synchroniser on rx. The deframer sees only the synchronised value.
- Deframer FSM (counter cnt, bit index idx[2:0], shift register):
  - IDLE: on synchronised rx=0, latch DIV, cnt=DIV/2 -> START.
  - START: at cnt==0, if rx=1 treat as a glitch -> IDLE; else cnt=DIV-1 -> DATA.
  - DATA: at cnt==0, sample rx into the shift register LSB-first, then idx++ and cnt=DIV-1. After idx 7 go to STOP (or PARITY when enabled).
  - STOP: at cnt==0, if rx=1 push the byte; else set frame_err and discard the byte. Go to IDLE; a new start bit is recognised next cycle.
- FIFO:
  - Push when full: byte discarded, overrun set, contents unchanged.
  - Push and pop in the same cycle: both happen and the count is unchanged. When the FIFO is empty with a same-cycle push, the pop read returns FFFF_FFFF and the pushed byte remains stored.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Sticky-flag priority: a W1C and a hardware set of the same flag in the same cycle leaves the flag set.
- Reset mid-frame: the partial byte is lost and FIFO contents are cleared; after release the FSM waits for a falling edge.
- irq_rx equals rx_avail, registered.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - PARITY state inserted between DATA and STOP. Expected bit is even parity of the 8 data bits, sampled at cnt==0.
  - On mismatch set parity_err and discard the byte after the stop bit. When the stop bit is also bad, both flags are set.
- Undefined:
  - No parity state; STATUS bit4 reads 0 and W1C to it has no effect.

Test Plan:
- Reset -> STATUS=0, DIV=434 (50 MHz/115200), irq_rx=0. DATA read -> FFFF_FFFF, mem_ready exactly 1 cycle after mem_valid.
- DIV=16, send 0x55 8N1 -> within 10 bit times STATUS=1 and irq_rx=1. DATA read -> 0x55, then STATUS=0 and DATA -> FFFF_FFFF.
- Send 17 bytes 0x00..0x10 without reading -> STATUS=0x7. 16 reads return 0x00..0x0F. Write STATUS=0x4 -> overrun clears.
- Frame with stop bit 0 -> frame_err set, FIFO stays empty. Then a 1-bit-time/4 low glitch on rx -> no byte pushed, FSM back to IDLE.
- Hold a DATA read at the same cycle a byte is pushed into a 1-entry FIFO -> old byte returned, count stays 1.
- Assert resetn low mid-byte, then release and send 0xA3 -> only 0xA3 received. Under UART_RX_PARITY_EN, 0xA3 with bad parity -> STATUS bit4=1, no byte stored.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped UART receiver for the PicoRV32 native bus.
//
// Deframes 8N1 serial data (optionally 8E1 parity check) from rx using a
// programmable clocks-per-bit divider, stores bytes in a FIFO, and exposes
// a small register window to the CPU:
//   addr[3:2]=0 DATA   read pops {24'b0,byte}; FFFF_FFFF when empty
//   addr[3:2]=1 STATUS {pe,fe,ov,full,avail}; bits 4:2 are write-1-to-clear
//   addr[3:2]=2 DIV    clocks per bit [15:0], values below 4 stored as 4
//   addr[3:2]=3 reads 0
//
// Compile-time option: define UART_RX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb  bus request (wstrb==0 means read)
//   mem_ready, mem_rdata        one-cycle acknowledge and read data
//   rx                          asynchronous serial input, idle high
//   irq_rx                      high while received bytes are waiting
//   dbg_state                   deframer state (0 idle, 1 start, 2 data,
//                               3 parity, 4 stop)
`timescale 1ns/1ps
module uart_rx_mmio #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        rx,
  output logic        irq_rx,
  output logic [2:0]  dbg_state
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST  = 16'(CLK_HZ / BAUD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_t;

  // ---------------- input synchroniser ----------------
  // All three flops reset low so that a line held low across reset release
  // is not mistaken for a start bit: a start needs a genuine 1->0 edge.
  logic rx_meta, rx_sync, rx_prev;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------- deframer FSM ----------------
  rx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n, fdiv, fdiv_n, div_reg;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        par_bad, par_bad_n;
  logic        push_req, set_fe, set_pe;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      fdiv    <= DIV_RST;
      idx     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      fdiv    <= fdiv_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    fdiv_n    = fdiv;
    idx_n     = idx;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    push_req  = 1'b0;
    set_fe    = 1'b0;
    set_pe    = 1'b0;
    case (state)
      S_IDLE: begin
        // DIV is latched per frame so bus writes never disturb a frame.
        if (rx_prev && !rx_sync) begin
          fdiv_n    = div_reg;
          cnt_n     = {1'b0, div_reg[15:1]};
          par_bad_n = 1'b0;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (cnt == 16'd0) begin
          if (rx_sync) begin
            state_n = S_IDLE;            // too short to be a start bit
          end else begin
            cnt_n   = fdiv - 16'd1;
            idx_n   = 3'd0;
            state_n = S_DATA;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == 16'd0) begin
          shreg_n = {rx_sync, shreg[7:1]};
          idx_n   = idx + 3'd1;
          cnt_n   = fdiv - 16'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == 16'd0) begin
          par_bad_n = (rx_sync != (^shreg));
          cnt_n     = fdiv - 16'd1;
          state_n   = S_STOP;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt == 16'd0) begin
          set_fe   = !rx_sync;
          set_pe   = par_bad;
          push_req = rx_sync && !par_bad;
          state_n  = S_IDLE;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // ---------------- bus and FIFO ----------------
  // Handshake: a request is accepted on a cycle with mem_valid && !mem_ready;
  // mem_ready is high for exactly the following cycle with mem_rdata valid,
  // so a request held through its ready cycle is never taken twice.
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        ov, fe, pe;
  logic        accept, is_wr, pop, push_ok, set_ov, avail, full;
  logic [1:0]  reg_sel;
  logic [2:0]  w1c;
  logic [31:0] rd_val;

  assign accept  = mem_valid && !mem_ready;
  assign is_wr   = |mem_wstrb;
  assign reg_sel = mem_addr[3:2];
  assign avail   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = accept && !is_wr && (reg_sel == 2'd0) && avail;
  assign push_ok = push_req && !full;
  assign set_ov  = push_req && full;
  assign w1c     = (accept && is_wr && (reg_sel == 2'd1)) ? mem_wdata[4:2] : 3'b000;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0:    rd_val = avail ? {24'd0, fifo_mem[rd_ptr]} : 32'hFFFF_FFFF;
      2'd1:    rd_val = {27'd0, pe, fe, ov, full, avail};
      2'd2:    rd_val = {16'd0, div_reg};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      irq_rx    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      div_reg   <= DIV_RST;
      ov        <= 1'b0;
      fe        <= 1'b0;
      pe        <= 1'b0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !is_wr) ? rd_val : 32'd0;
      irq_rx    <= avail;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (accept && is_wr && (reg_sel == 2'd2))
        div_reg <= (mem_wdata[15:0] < 16'd4) ? 16'd4 : mem_wdata[15:0];
      // A hardware set wins over a same-cycle clear.
      ov <= (ov & ~w1c[0]) | set_ov;
      fe <= (fe & ~w1c[1]) | set_fe;
`ifdef UART_RX_PARITY_EN
      pe <= (pe & ~w1c[2]) | set_pe;
`else
      pe <= 1'b0;
`endif
    end
  end

  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], set_pe, w1c[2]};

endmodule
